// File: rtl/rv_pkg.sv
// Shared encodings for the rv_pipe_core pipeline: opcodes, function fields,
// control enums, the decoded-control bundle and immediate extraction.
package rv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        alu_ctrl_e   alu_ctrl;
        imm_src_e    imm_src;
        logic        use_rs1;
        logic        use_rs2;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_write:  1'b0,
        result_src: RES_ALU,
        mem_write:  1'b0,
        jump:       1'b0,
        branch:     1'b0,
        alu_src:    1'b0,
        alu_ctrl:   ALU_ADD,
        imm_src:    IMM_I,
        use_rs1:    1'b0,
        use_rs2:    1'b0
    };

    function automatic logic [31:0] imm_ext(input logic [31:0] instr, input imm_src_e src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// x0 fixed at zero, write-first bypass so a W-stage write is visible in D.
module rv_regfile
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs_r [0:31];

    // Register storage; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (we && (wa != 5'd0)) begin
            regs_r[wa] <= wd;
        end
    end

    // Read port 1 with same-cycle write bypass.
    always_comb begin
        if (ra1 == 5'd0) begin
            rd1 = 32'h0000_0000;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end else begin
            rd1 = regs_r[ra1];
        end
    end

    // Read port 2 with same-cycle write bypass.
    always_comb begin
        if (ra2 == 5'd0) begin
            rd2 = 32'h0000_0000;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end else begin
            rd2 = regs_r[ra2];
        end
    end

endmodule

// File: rtl/rv_pipe_core.sv
// Five-stage in-order RV32I-subset pipeline (F/D/E/M/W) with M-over-W
// forwarding, one-cycle load-use stall and branch/jal resolution in E.
module rv_pipe_core
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrF,
    input  logic [31:0] ReadData,
    output logic        MemWrite,
    output logic [31:0] ALUResult,
    output logic [31:0] WriteData,
    output logic [31:0] PCF
);

    logic [31:0] pc_f_r;
    logic [31:0] instr_d_r, pc_d_r;
    logic [6:0]  opcode_d_s, funct7_d_s;
    logic [2:0]  funct3_d_s;
    logic [4:0]  rd_d_s, rs1_d_s, rs2_d_s;
    ctrl_t       ctrl_d_s;
    alu_ctrl_e   alu_f3_s;
    logic        alu_f3_ok_s;
    logic [31:0] imm_d_s, rd1_d_s, rd2_d_s;

    logic        reg_write_e_r, mem_write_e_r, jump_e_r, branch_e_r, alu_src_e_r;
    result_src_e result_src_e_r;
    alu_ctrl_e   alu_ctrl_e_r;
    logic [2:0]  funct3_e_r;
    logic [31:0] rd1_e_r, rd2_e_r, pc_e_r, imm_e_r;
    logic [4:0]  rs1_e_r, rs2_e_r, rd_e_r;
    logic [31:0] src_a_s, fwd_b_s, src_b_s, alu_out_s, ex_result_s, pc_target_s;
    logic        lt_s, take_s, pc_src_s;

    logic        reg_write_m_r, mem_write_m_r;
    result_src_e result_src_m_r;
    logic [31:0] alu_result_m_r, write_data_m_r;
    logic [4:0]  rd_m_r;

    logic        reg_write_w_r;
    result_src_e result_src_w_r;
    logic [31:0] alu_result_w_r, read_data_w_r, result_w_s;
    logic [4:0]  rd_w_r;

    logic        lw_stall_s, flush_d_s, flush_e_s;

    // Fetch: a redirect from E outranks the load-use hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f_r <= RESET_PC;
        end else if (pc_src_s) begin
            pc_f_r <= pc_target_s;
        end else if (!lw_stall_s) begin
            pc_f_r <= pc_f_r + 32'd4;
        end
    end

    // F/D register; an all-zero word decodes as a bubble.
    always_ff @(posedge clk) begin
        if (!reset || flush_d_s) begin
            instr_d_r <= 32'h0000_0000;
            pc_d_r    <= 32'h0000_0000;
        end else if (!lw_stall_s) begin
            instr_d_r <= InstrF;
            pc_d_r    <= pc_f_r;
        end
    end

    assign opcode_d_s = instr_d_r[6:0];
    assign rd_d_s     = instr_d_r[11:7];
    assign funct3_d_s = instr_d_r[14:12];
    assign funct7_d_s = instr_d_r[31:25];
    // Unused source fields read as x0 so they never trigger forwarding or stalls.
    assign rs1_d_s    = ctrl_d_s.use_rs1 ? instr_d_r[19:15] : 5'd0;
    assign rs2_d_s    = ctrl_d_s.use_rs2 ? instr_d_r[24:20] : 5'd0;
    assign imm_d_s    = imm_ext(instr_d_r, ctrl_d_s.imm_src);

    // ALU operation shared by R- and I-type arithmetic.
    always_comb begin
        alu_f3_s    = ALU_ADD;
        alu_f3_ok_s = 1'b1;
        case (funct3_d_s)
            F3_ADD_SUB: alu_f3_s = ALU_ADD;
            F3_SLT:     alu_f3_s = ALU_SLT;
            F3_OR:      alu_f3_s = ALU_OR;
            F3_AND:     alu_f3_s = ALU_AND;
            default:    alu_f3_ok_s = 1'b0;
        endcase
    end

    // Main control decode; anything unrecognised stays a NOP.
    always_comb begin
        ctrl_d_s = CTRL_NOP;
        case (opcode_d_s)
            OP_R: begin
                if ((funct7_d_s == F7_SUB) && (funct3_d_s == F3_ADD_SUB)) begin
                    ctrl_d_s.reg_write = 1'b1;
                    ctrl_d_s.alu_ctrl  = ALU_SUB;
                    ctrl_d_s.use_rs1   = 1'b1;
                    ctrl_d_s.use_rs2   = 1'b1;
                end else if ((funct7_d_s == F7_BASE) && alu_f3_ok_s) begin
                    ctrl_d_s.reg_write = 1'b1;
                    ctrl_d_s.alu_ctrl  = alu_f3_s;
                    ctrl_d_s.use_rs1   = 1'b1;
                    ctrl_d_s.use_rs2   = 1'b1;
                end else begin
                    ctrl_d_s = CTRL_NOP;
                end
            end
            OP_I: begin
                if (alu_f3_ok_s) begin
                    ctrl_d_s.reg_write = 1'b1;
                    ctrl_d_s.alu_src   = 1'b1;
                    ctrl_d_s.alu_ctrl  = alu_f3_s;
                    ctrl_d_s.use_rs1   = 1'b1;
                end else begin
                    ctrl_d_s = CTRL_NOP;
                end
            end
            OP_LW: begin
                if (funct3_d_s == F3_LW_SW) begin
                    ctrl_d_s.reg_write  = 1'b1;
                    ctrl_d_s.result_src = RES_MEM;
                    ctrl_d_s.alu_src    = 1'b1;
                    ctrl_d_s.use_rs1    = 1'b1;
                end else begin
                    ctrl_d_s = CTRL_NOP;
                end
            end
            OP_SW: begin
                if (funct3_d_s == F3_LW_SW) begin
                    ctrl_d_s.mem_write = 1'b1;
                    ctrl_d_s.alu_src   = 1'b1;
                    ctrl_d_s.imm_src   = IMM_S;
                    ctrl_d_s.use_rs1   = 1'b1;
                    ctrl_d_s.use_rs2   = 1'b1;
                end else begin
                    ctrl_d_s = CTRL_NOP;
                end
            end
            OP_BR: begin
                // beq/bne/blt/bge are exactly the funct3 codes with bit 1 clear.
                if (funct3_d_s[1] == 1'b0) begin
                    ctrl_d_s.branch  = 1'b1;
                    ctrl_d_s.imm_src = IMM_B;
                    ctrl_d_s.use_rs1 = 1'b1;
                    ctrl_d_s.use_rs2 = 1'b1;
                end else begin
                    ctrl_d_s = CTRL_NOP;
                end
            end
            OP_JAL: begin
                ctrl_d_s.reg_write  = 1'b1;
                ctrl_d_s.result_src = RES_PC4;
                ctrl_d_s.jump       = 1'b1;
                ctrl_d_s.imm_src    = IMM_J;
            end
            default: ctrl_d_s = CTRL_NOP;
        endcase
    end

    rv_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs1_d_s),
        .ra2   (rs2_d_s),
        .we    (reg_write_w_r),
        .wa    (rd_w_r),
        .wd    (result_w_s),
        .rd1   (rd1_d_s),
        .rd2   (rd2_d_s)
    );

    // D/E register; cleared to a bubble on reset, redirect or load-use.
    always_ff @(posedge clk) begin
        if (!reset || flush_e_s) begin
            reg_write_e_r  <= 1'b0;
            result_src_e_r <= RES_ALU;
            mem_write_e_r  <= 1'b0;
            jump_e_r       <= 1'b0;
            branch_e_r     <= 1'b0;
            alu_src_e_r    <= 1'b0;
            alu_ctrl_e_r   <= ALU_ADD;
            funct3_e_r     <= 3'b000;
            rd1_e_r        <= 32'h0000_0000;
            rd2_e_r        <= 32'h0000_0000;
            pc_e_r         <= 32'h0000_0000;
            imm_e_r        <= 32'h0000_0000;
            rs1_e_r        <= 5'd0;
            rs2_e_r        <= 5'd0;
            rd_e_r         <= 5'd0;
        end else begin
            reg_write_e_r  <= ctrl_d_s.reg_write;
            result_src_e_r <= ctrl_d_s.result_src;
            mem_write_e_r  <= ctrl_d_s.mem_write;
            jump_e_r       <= ctrl_d_s.jump;
            branch_e_r     <= ctrl_d_s.branch;
            alu_src_e_r    <= ctrl_d_s.alu_src;
            alu_ctrl_e_r   <= ctrl_d_s.alu_ctrl;
            funct3_e_r     <= funct3_d_s;
            rd1_e_r        <= rd1_d_s;
            rd2_e_r        <= rd2_d_s;
            pc_e_r         <= pc_d_r;
            imm_e_r        <= imm_d_s;
            rs1_e_r        <= rs1_d_s;
            rs2_e_r        <= rs2_d_s;
            rd_e_r         <= rd_d_s;
        end
    end

    // Operand forwarding, M stage before W stage.
    always_comb begin
        if (reg_write_m_r && (rd_m_r != 5'd0) && (rd_m_r == rs1_e_r)) begin
            src_a_s = alu_result_m_r;
        end else if (reg_write_w_r && (rd_w_r != 5'd0) && (rd_w_r == rs1_e_r)) begin
            src_a_s = result_w_s;
        end else begin
            src_a_s = rd1_e_r;
        end
        if (reg_write_m_r && (rd_m_r != 5'd0) && (rd_m_r == rs2_e_r)) begin
            fwd_b_s = alu_result_m_r;
        end else if (reg_write_w_r && (rd_w_r != 5'd0) && (rd_w_r == rs2_e_r)) begin
            fwd_b_s = result_w_s;
        end else begin
            fwd_b_s = rd2_e_r;
        end
    end

    assign src_b_s = alu_src_e_r ? imm_e_r : fwd_b_s;
    assign lt_s    = $signed(src_a_s) < $signed(fwd_b_s);

    // ALU and branch condition.
    always_comb begin
        case (alu_ctrl_e_r)
            ALU_ADD: alu_out_s = src_a_s + src_b_s;
            ALU_SUB: alu_out_s = src_a_s - src_b_s;
            ALU_AND: alu_out_s = src_a_s & src_b_s;
            ALU_OR:  alu_out_s = src_a_s | src_b_s;
            ALU_SLT: alu_out_s = {31'h0000_0000, $signed(src_a_s) < $signed(src_b_s)};
            default: alu_out_s = src_a_s + src_b_s;
        endcase
        case (funct3_e_r)
            F3_BEQ:  take_s = (src_a_s == fwd_b_s);
            F3_BNE:  take_s = (src_a_s != fwd_b_s);
            F3_BLT:  take_s = lt_s;
            F3_BGE:  take_s = !lt_s;
            default: take_s = 1'b0;
        endcase
    end

    assign pc_target_s = pc_e_r + imm_e_r;
    assign pc_src_s    = jump_e_r | (branch_e_r & take_s);
    // jal's link value rides the ALU-result path so M-stage forwarding sees it.
    assign ex_result_s = (result_src_e_r == RES_PC4) ? (pc_e_r + 32'd4) : alu_out_s;

    // E/M register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write_m_r  <= 1'b0;
            result_src_m_r <= RES_ALU;
            mem_write_m_r  <= 1'b0;
            alu_result_m_r <= 32'h0000_0000;
            write_data_m_r <= 32'h0000_0000;
            rd_m_r         <= 5'd0;
        end else begin
            reg_write_m_r  <= reg_write_e_r;
            result_src_m_r <= result_src_e_r;
            mem_write_m_r  <= mem_write_e_r;
            alu_result_m_r <= ex_result_s;
            write_data_m_r <= fwd_b_s;
            rd_m_r         <= rd_e_r;
        end
    end

    // M/W register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write_w_r  <= 1'b0;
            result_src_w_r <= RES_ALU;
            alu_result_w_r <= 32'h0000_0000;
            read_data_w_r  <= 32'h0000_0000;
            rd_w_r         <= 5'd0;
        end else begin
            reg_write_w_r  <= reg_write_m_r;
            result_src_w_r <= result_src_m_r;
            alu_result_w_r <= alu_result_m_r;
            read_data_w_r  <= ReadData;
            rd_w_r         <= rd_m_r;
        end
    end

    assign result_w_s = (result_src_w_r == RES_MEM) ? read_data_w_r : alu_result_w_r;

    // Load-use detection against the D-stage sources.
    always_comb begin
        if ((result_src_e_r == RES_MEM) && reg_write_e_r && (rd_e_r != 5'd0)) begin
            lw_stall_s = (rd_e_r == rs1_d_s) || (rd_e_r == rs2_d_s);
        end else begin
            lw_stall_s = 1'b0;
        end
    end

    assign flush_d_s = pc_src_s;
    assign flush_e_s = pc_src_s | lw_stall_s;

    assign PCF       = pc_f_r;
    assign ALUResult = alu_result_m_r;
    assign WriteData = write_data_m_r;
    // Store strobe is suppressed for the whole time reset is held.
    assign MemWrite  = mem_write_m_r & reset;

endmodule

// File: tb/tb_rv_pipe_core.sv
// Directed-program bench for rv_pipe_core with behavioural instruction and
// data memories; expected PCF and store values are hand-computed per cycle.
module tb_rv_pipe_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] InstrF, ReadData, ALUResult, WriteData, PCF;
    logic        MemWrite;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:255];
    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    rv_pipe_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .InstrF    (InstrF),
        .ReadData  (ReadData),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .PCF       (PCF)
    );

    always #5 clk = ~clk;

    assign InstrF   = imem[PCF[7:2]];
    assign ReadData = dmem[ALUResult[9:2]];

    always @(posedge clk) begin
        if (MemWrite) dmem[ALUResult[9:2]] <= WriteData;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_store(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check_vec({tag, "_memwrite"}, {31'h0, MemWrite}, 32'h1);
        check_vec({tag, "_addr"}, ALUResult, addr);
        check_vec({tag, "_wdata"}, WriteData, data);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
    endtask

    task automatic start_prog(input string tag);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_vec({tag, "_rst_pcf"}, PCF, 32'h0);
            check_vec({tag, "_rst_memwrite"}, {31'h0, MemWrite}, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return enc_i(7'b0010011, 3'b000, rd, rs1, imm);
    endfunction

    localparam logic [6:0] OPI = 7'b0010011;

    initial begin
        // Reset and sequential fetch over NOPs.
        clear_prog();
        start_prog("t1");
        for (int n = 0; n < 4; n++) begin
            goto(n);
            check_vec("t1_pcf_seq", PCF, 32'(4 * n));
            check_vec("t1_memwrite", {31'h0, MemWrite}, 32'h0);
        end

        // Forwarding from W and M into add, then into sw data.
        clear_prog();
        imem[0] = addi(5'd1, 5'd0, 32'd5);
        imem[1] = addi(5'd2, 5'd0, 32'd7);
        imem[2] = enc_r(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2);
        imem[3] = enc_s(5'd3, 5'd0, 32'h40);
        start_prog("t2");
        goto(5);
        check_vec("t2_no_early_store", {31'h0, MemWrite}, 32'h0);
        goto(6);
        check_store("t2_sw", 32'h40, 32'd12);
        goto(7);
        check_vec("t2_dmem40", dmem[16], 32'd12);

        // Load-use: one-cycle hold of PCF, then forwarded load data.
        clear_prog();
        imem[0] = enc_i(7'b0000011, 3'b010, 5'd4, 5'd0, 32'h40);
        imem[1] = enc_r(7'b0000000, 3'b000, 5'd5, 5'd4, 5'd4);
        imem[2] = enc_s(5'd5, 5'd0, 32'h44);
        start_prog("t3");
        goto(2);
        check_vec("t3_pcf_c2", PCF, 32'h8);
        goto(3);
        check_vec("t3_pcf_hold", PCF, 32'h8);
        goto(4);
        check_vec("t3_pcf_c4", PCF, 32'hC);
        goto(5);
        check_vec("t3_bubble", {31'h0, MemWrite}, 32'h0);
        goto(6);
        check_store("t3_sw", 32'h44, 32'd24);

        // Taken beq flushes the two younger instructions.
        clear_prog();
        imem[0] = addi(5'd1, 5'd0, 32'd1);
        imem[1] = enc_b(3'b000, 5'd1, 5'd1, 32'd12);
        imem[2] = addi(5'd7, 5'd0, 32'd9);
        imem[3] = addi(5'd8, 5'd0, 32'd9);
        imem[4] = enc_s(5'd1, 5'd0, 32'h48);
        imem[5] = enc_s(5'd7, 5'd0, 32'h4C);
        imem[6] = enc_s(5'd8, 5'd0, 32'h50);
        start_prog("t4");
        goto(3);
        check_vec("t4_pcf_c3", PCF, 32'hC);
        goto(4);
        check_vec("t4_pcf_target", PCF, 32'h10);
        goto(7);
        check_store("t4_sw_x1", 32'h48, 32'd1);
        goto(8);
        check_store("t4_sw_x7", 32'h4C, 32'd0);
        goto(9);
        check_store("t4_sw_x8", 32'h50, 32'd0);

        // bne not taken, signed blt taken, jal link value.
        clear_prog();
        imem[0]  = addi(5'd1, 5'd0, 32'hFFFF_FFFF);
        imem[1]  = addi(5'd2, 5'd0, 32'd1);
        imem[2]  = enc_b(3'b001, 5'd0, 5'd0, 32'd8);
        imem[3]  = addi(5'd9, 5'd0, 32'd3);
        imem[4]  = enc_b(3'b100, 5'd1, 5'd2, 32'd16);
        imem[5]  = addi(5'd10, 5'd0, 32'd5);
        imem[6]  = addi(5'd11, 5'd0, 32'd5);
        imem[7]  = addi(5'd10, 5'd0, 32'd6);
        imem[8]  = enc_j(5'd6, 32'd8);
        imem[9]  = addi(5'd6, 5'd0, 32'd1);
        imem[10] = enc_s(5'd6, 5'd0, 32'h54);
        imem[11] = enc_s(5'd9, 5'd0, 32'h58);
        imem[12] = enc_s(5'd10, 5'd0, 32'h5C);
        start_prog("t5");
        goto(5);
        check_vec("t5_bne_no_bubble", PCF, 32'h14);
        goto(7);
        check_vec("t5_blt_target", PCF, 32'h20);
        goto(10);
        check_vec("t5_jal_target", PCF, 32'h28);
        goto(11);
        check_vec("t5_after_jal", PCF, 32'h2C);
        goto(13);
        check_store("t5_sw_x6", 32'h54, 32'h24);
        goto(14);
        check_store("t5_sw_x9", 32'h58, 32'd3);
        goto(15);
        check_store("t5_sw_x10", 32'h5C, 32'd0);

        // ALU coverage: sub/and/or/slt/slti/andi/ori with negative operands.
        clear_prog();
        imem[0]  = addi(5'd1, 5'd0, 32'hFFFF_FFFD);
        imem[1]  = addi(5'd2, 5'd0, 32'd5);
        imem[2]  = enc_r(7'b0100000, 3'b000, 5'd3, 5'd1, 5'd2);
        imem[3]  = enc_r(7'b0000000, 3'b111, 5'd4, 5'd1, 5'd2);
        imem[4]  = enc_r(7'b0000000, 3'b110, 5'd5, 5'd1, 5'd2);
        imem[5]  = enc_r(7'b0000000, 3'b010, 5'd6, 5'd1, 5'd2);
        imem[6]  = enc_i(OPI, 3'b010, 5'd7, 5'd2, 32'hFFFF_FFFF);
        imem[7]  = enc_i(OPI, 3'b111, 5'd8, 5'd1, 32'h0F);
        imem[8]  = enc_i(OPI, 3'b110, 5'd9, 5'd2, 32'h70);
        for (int k = 0; k < 7; k++) begin
            imem[9 + k] = enc_s(5'(3 + k), 5'd0, 32'(32'h60 + 4 * k));
        end
        start_prog("t6");
        goto(20);
        check_vec("t6_sub", dmem[24], 32'hFFFF_FFF8);
        check_vec("t6_and", dmem[25], 32'h0000_0005);
        check_vec("t6_or", dmem[26], 32'hFFFF_FFFD);
        check_vec("t6_slt", dmem[27], 32'h0000_0001);
        check_vec("t6_slti", dmem[28], 32'h0000_0000);
        check_vec("t6_andi", dmem[29], 32'h0000_000D);
        check_vec("t6_ori", dmem[30], 32'h0000_0075);

        // Reset while sw is in E: nothing commits, registers are cleared.
        clear_prog();
        imem[0] = addi(5'd1, 5'd0, 32'd5);
        imem[1] = addi(5'd2, 5'd0, 32'd7);
        imem[2] = enc_r(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2);
        imem[3] = enc_s(5'd3, 5'd0, 32'h40);
        start_prog("t7");
        goto(5);
        reset = 1'b0;
        check_vec("t7_memwrite_held", {31'h0, MemWrite}, 32'h0);
        step();
        check_vec("t7_memwrite_next", {31'h0, MemWrite}, 32'h0);
        check_vec("t7_pcf_next", PCF, 32'h0);
        clear_prog();
        imem[0] = enc_s(5'd1, 5'd0, 32'h70);
        step();
        reset = 1'b1;
        cyc = 0;
        goto(3);
        check_store("t7_x1_cleared", 32'h70, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
